disp_seg_mux_n: RTL

Parametrised time-multiplexed seven-segment display driver for the stopwatch/UART display path. It holds a DIGITS-entry character buffer written one digit per cycle, then scans the digits onto shared segment lines. Per-digit blinking, 16-level PWM brightness, anti-ghosting dead time and optional leading-zero blanking are included. A frame_tick pulse marks the end of every full scan.

---
 rtl/disp_seg_mux_n.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/disp_seg_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : disp_seg_mux_n
// Brief    : Time-multiplexed seven-segment driver with blink, PWM brightness,
//            dead time and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module disp_seg_mux_n #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_LOG2   = 16,
    parameter int DEAD_CYC       = 4,
    parameter int BLINK_LOG2     = 24,
    parameter int SEL_ACTIVE_LOW = 1,
    localparam int AW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [5:0]        wr_data,
    input  logic [DIGITS-1:0] blink_mask,
    input  logic [3:0]        brightness,
    input  logic              blank_lz,
    output logic [7:0]        sseg,
    output logic [DIGITS-1:0] sel,
    output logic              frame_tick
);

    localparam logic [5:0]              c_blank_entry = 6'b0_11101;
    localparam logic [AW-1:0]           c_last_digit  = AW'(DIGITS - 1);
    localparam logic [REFRESH_LOG2-1:0] c_dead        = REFRESH_LOG2'(DEAD_CYC);
    localparam logic                    c_sel_on      = (SEL_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [DIGITS-1:0]       c_sel_idle    = {DIGITS{~c_sel_on}};

    logic [REFRESH_LOG2-1:0] r_slot_cnt;
    logic [AW-1:0]           r_digit_idx;
    logic [BLINK_LOG2:0]     r_blink_cnt;
    logic [5:0]              r_buf [DIGITS];

    logic                    w_slot_last;
    logic                    w_frame_end;
    logic [3:0]              w_phase;
    logic                    w_sel_en;
    logic [DIGITS-1:0]       w_lz_run;
    logic [5:0]              w_cur;
    logic                    w_mask_bit;
    logic                    w_lz_hit;
    logic                    w_blank;
    logic [7:0]              w_sseg_nxt;
    logic [DIGITS-1:0]       w_sel_nxt;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g}
    function automatic logic [6:0] f_glyph(input logic [4:0] ch);
        case (ch)
            5'd0:  f_glyph = 7'b0000001;
            5'd1:  f_glyph = 7'b1001111;
            5'd2:  f_glyph = 7'b0010010;
            5'd3:  f_glyph = 7'b0000110;
            5'd4:  f_glyph = 7'b1001100;
            5'd5:  f_glyph = 7'b0100100;
            5'd6:  f_glyph = 7'b0100000;
            5'd7:  f_glyph = 7'b0001111;
            5'd8:  f_glyph = 7'b0000000;
            5'd9:  f_glyph = 7'b0000100;
            5'd10: f_glyph = 7'b0001000;
            5'd11: f_glyph = 7'b1100000;
            5'd12: f_glyph = 7'b0110001;
            5'd13: f_glyph = 7'b1000010;
            5'd14: f_glyph = 7'b0110000;
            5'd15: f_glyph = 7'b0111000;
            5'd16: f_glyph = 7'b0100001;
            5'd17: f_glyph = 7'b1001000;
            5'd18: f_glyph = 7'b1111001;
            5'd19: f_glyph = 7'b1000011;
            5'd20: f_glyph = 7'b1110001;
            5'd21: f_glyph = 7'b0001001;
            5'd22: f_glyph = 7'b0000001;
            5'd23: f_glyph = 7'b0011000;
            5'd24: f_glyph = 7'b1111010;
            5'd25: f_glyph = 7'b0100100;
            5'd26: f_glyph = 7'b1000001;
            5'd27: f_glyph = 7'b1000100;
            5'd28: f_glyph = 7'b0010010;
            5'd30: f_glyph = 7'b1111110;
            default: f_glyph = 7'b1111111;
        endcase
    endfunction

    assign w_slot_last = &r_slot_cnt;
    assign w_frame_end = w_slot_last && (r_digit_idx == c_last_digit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_slot_cnt  <= r_slot_cnt + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (w_slot_last) begin
                r_digit_idx <= (r_digit_idx == c_last_digit) ? '0 : r_digit_idx + 1'b1;
            end
        end
    end

    // Addresses >= DIGITS match no entry and are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGITS; i++) r_buf[i] <= c_blank_entry;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) r_buf[i] <= wr_data;
            end
        end
    end

    // w_lz_run[i]: every entry from i up to the top digit is an all-zero code
    always_comb begin
        w_lz_run = '0;
        w_lz_run[DIGITS-1] = (r_buf[DIGITS-1] == 6'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            w_lz_run[i] = (r_buf[i] == 6'd0) && w_lz_run[i+1];
        end
    end

    always_comb begin
        w_cur      = c_blank_entry;
        w_mask_bit = 1'b0;
        w_lz_hit   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit_idx == AW'(i)) begin
                w_cur      = r_buf[i];
                w_mask_bit = blink_mask[i];
                w_lz_hit   = w_lz_run[i] && (i != 0);
            end
        end
    end

    assign w_phase    = r_slot_cnt[REFRESH_LOG2-1 -: 4];
    assign w_sel_en   = (r_slot_cnt >= c_dead) && (w_phase <= brightness);
    assign w_blank    = (r_blink_cnt[BLINK_LOG2] && w_mask_bit) || (blank_lz && w_lz_hit);
    assign w_sseg_nxt = w_blank ? 8'hFF : {~w_cur[5], f_glyph(w_cur[4:0])};

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
        assign w_sel_nxt[gi] = ((r_digit_idx == AW'(gi)) && w_sel_en) ? c_sel_on : ~c_sel_on;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sseg       <= 8'hFF;
            sel        <= c_sel_idle;
            frame_tick <= 1'b0;
        end else begin
            sseg       <= w_sseg_nxt;
            sel        <= w_sel_nxt;
            frame_tick <= w_frame_end;
        end
    end

endmodule
`default_nettype wire
